// File: rtl/vu_cycle_sequencer.sv
// Bus-cycle sequencer: follows a RAS-framed bus cycle, classifies the strobe and
// queues one {kind, addr, data} event per completed cycle in a show-ahead FIFO.
module vu_cycle_sequencer #(
   parameter int unsigned TIMEOUT = 31,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        negedge_ras_n,
   input  logic        posedge_ras_n,
   input  logic        negedge_zpzu_n,
   input  logic        negedge_chtzu_n,
   input  logic        negedge_zpvv_n,
   input  logic        negedge_chtvv_n,
   input  logic        clean_stack,
   input  logic        addr_valid,
   input  logic [15:0] addr,
   input  logic [7:0]  shavv,
   output logic        ev_valid,
   output logic [2:0]  ev_kind,
   output logic [15:0] ev_addr,
   output logic [7:0]  ev_data,
   input  logic        ev_ready,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic        timeout_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      ROW,
      ADDR,
      CAPTURE,
      WAIT_END
   } state_t;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] addr;
      logic [7:0]  data;
   } event_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [15:0]     addr_q, addr_d;
   logic [2:0]      kind_q, kind_d;
   logic            push;
   logic            timeout_hit;

   event_t          mem_q [DEPTH];
   event_t          mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            pop;
   logic            push_ok;
   logic            any_strobe;
   logic [1:0]      strobe_code;
   event_t          head;

   // Strobe priority: IO write > IO read > memory write > memory read.
   always_comb begin
      any_strobe  = negedge_zpvv_n | negedge_chtvv_n | negedge_zpzu_n | negedge_chtzu_n;
      strobe_code = 2'd0;
      if (negedge_zpvv_n) begin
         strobe_code = 2'd3;
      end else if (negedge_chtvv_n) begin
         strobe_code = 2'd2;
      end else if (negedge_zpzu_n) begin
         strobe_code = 2'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      addr_d      = addr_q;
      kind_d      = kind_q;
      push        = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (negedge_ras_n) begin
               state_d = ROW;
               tmo_d   = '0;
            end
         end
         ROW: begin
            if (negedge_ras_n) begin
               tmo_d = '0;
            end else if (addr_valid) begin
               state_d = ADDR;
               addr_d  = addr;
            end else if (posedge_ras_n) begin
               state_d = IDLE;
            end else if (tmo_q >= TO_LAST) begin
               state_d     = IDLE;
               timeout_hit = 1'b1;
            end else if (tmo_q != TO_MAX) begin
               tmo_d = tmo_q + TO_ONE;
            end
         end
         ADDR: begin
            if (negedge_ras_n) begin
               state_d = ROW;
               tmo_d   = '0;
            end else if (any_strobe) begin
               state_d = CAPTURE;
               kind_d  = {clean_stack, strobe_code};
            end else if (posedge_ras_n) begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            // The push always completes; a RAS fall here only picks the next state.
            push = 1'b1;
            if (negedge_ras_n) begin
               state_d = ROW;
               tmo_d   = '0;
            end else begin
               state_d = WAIT_END;
            end
         end
         WAIT_END: begin
            if (negedge_ras_n) begin
               state_d = ROW;
               tmo_d   = '0;
            end else if (posedge_ras_n) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop     = ev_ready && (count_q != '0);
      push_ok = push && ((count_q != CNT_FULL) || pop);

      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok) begin
         mem_d[wr_ptr_q] = '{kind: kind_q, addr: addr_q, data: shavv};
      end

      wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!push_ok && pop) begin
         count_d = count_q - CNT_ONE;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      overflow_d = overflow_q;
      if (ovf_clr) begin
         overflow_d = 1'b0;
      end
      if (push && !push_ok) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         addr_q     <= '0;
         kind_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         addr_q     <= addr_d;
         kind_q     <= kind_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      ev_valid    = (count_q != '0);
      head        = ev_valid ? mem_q[rd_ptr_q] : '0;
      ev_kind     = head.kind;
      ev_addr     = head.addr;
      ev_data     = head.data;
      overflow    = overflow_q;
      timeout_err = timeout_hit && !reset;
      busy        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_vu_cycle_sequencer.sv
// Directed bench for vu_cycle_sequencer: each task drives one scenario and checks inline.
module tb_vu_cycle_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        negedge_ras_n = 1'b0, posedge_ras_n = 1'b0;
   logic        negedge_zpzu_n = 1'b0, negedge_chtzu_n = 1'b0;
   logic        negedge_zpvv_n = 1'b0, negedge_chtvv_n = 1'b0;
   logic        clean_stack = 1'b0, addr_valid = 1'b0;
   logic [15:0] addr = '0;
   logic [7:0]  shavv = '0;
   logic        ev_valid;
   logic [2:0]  ev_kind;
   logic [15:0] ev_addr;
   logic [7:0]  ev_data;
   logic        ev_ready = 1'b0;
   logic        overflow;
   logic        ovf_clr = 1'b0;
   logic        timeout_err;
   logic        busy;

   int checks = 0;
   int failures = 0;

   vu_cycle_sequencer #(.TIMEOUT(31), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .negedge_ras_n(negedge_ras_n), .posedge_ras_n(posedge_ras_n),
      .negedge_zpzu_n(negedge_zpzu_n), .negedge_chtzu_n(negedge_chtzu_n),
      .negedge_zpvv_n(negedge_zpvv_n), .negedge_chtvv_n(negedge_chtvv_n),
      .clean_stack(clean_stack), .addr_valid(addr_valid), .addr(addr), .shavv(shavv),
      .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_addr(ev_addr), .ev_data(ev_data),
      .ev_ready(ev_ready), .overflow(overflow), .ovf_clr(ovf_clr),
      .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // IDLE -> ROW -> ADDR with the given address latched.
   task automatic start_addr(input logic [15:0] a);
      negedge_ras_n = 1'b1;
      tick();
      negedge_ras_n = 1'b0;
      addr_valid = 1'b1;
      addr = a;
      tick();
      addr_valid = 1'b0;
   endtask

   // strb = {zpvv, chtvv, zpzu, chtzu}; ADDR -> CAPTURE.
   task automatic strobe(input logic [3:0] strb, input logic stack);
      {negedge_zpvv_n, negedge_chtvv_n, negedge_zpzu_n, negedge_chtzu_n} = strb;
      clean_stack = stack;
      tick();
      {negedge_zpvv_n, negedge_chtvv_n, negedge_zpzu_n, negedge_chtzu_n} = 4'b0000;
      clean_stack = 1'b0;
   endtask

   task automatic capture(input logic [7:0] d);
      shavv = d;
      tick();
      shavv = 8'h00;
   endtask

   task automatic end_ras();
      posedge_ras_n = 1'b1;
      tick();
      posedge_ras_n = 1'b0;
   endtask

   task automatic full_cycle(input logic [15:0] a, input logic [3:0] strb, input logic stack, input logic [7:0] d);
      start_addr(a);
      strobe(strb, stack);
      capture(d);
      end_ras();
   endtask

   task automatic test_reset();
      negedge_ras_n = 1'b1;
      do_reset();
      negedge_ras_n = 1'b0;
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", ev_valid); end
      checks++; if (ev_kind !== 3'd0) begin failures++; $display("FAIL rst_kind got=%0d exp=0", ev_kind); end
      checks++; if (ev_addr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", ev_addr); end
      checks++; if (ev_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", ev_data); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", overflow); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_tmo got=%0b exp=0", timeout_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_basic_write();
      ev_ready = 1'b1;
      start_addr(16'h8123);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
      strobe(4'b0010, 1'b0);
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%0b exp=0", ev_valid); end
      capture(8'h5A);
      checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL basic_lat2 got=%0b exp=1", ev_valid); end
      checks++; if (ev_kind !== 3'd1) begin failures++; $display("FAIL basic_kind got=%0d exp=1", ev_kind); end
      checks++; if (ev_addr !== 16'h8123) begin failures++; $display("FAIL basic_addr got=%h exp=8123", ev_addr); end
      checks++; if (ev_data !== 8'h5A) begin failures++; $display("FAIL basic_data got=%h exp=5a", ev_data); end
      end_ras();
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%0b exp=0", ev_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0b exp=0", busy); end
   endtask

   task automatic test_priority();
      ev_ready = 1'b0;
      full_cycle(16'h0042, 4'b1001, 1'b1, 8'h33);
      full_cycle(16'h0077, 4'b0110, 1'b0, 8'h44);
      full_cycle(16'h0303, 4'b0001, 1'b0, 8'h55);
      checks++; if (ev_kind !== 3'd7 || ev_addr !== 16'h0042 || ev_data !== 8'h33) begin failures++; $display("FAIL prio_iow got=%0d/%h/%h exp=7/0042/33", ev_kind, ev_addr, ev_data); end
      ev_ready = 1'b1;
      tick();
      checks++; if (ev_kind !== 3'd2 || ev_addr !== 16'h0077 || ev_data !== 8'h44) begin failures++; $display("FAIL prio_ior got=%0d/%h/%h exp=2/0077/44", ev_kind, ev_addr, ev_data); end
      tick();
      checks++; if (ev_kind !== 3'd0 || ev_addr !== 16'h0303 || ev_data !== 8'h55) begin failures++; $display("FAIL prio_mr got=%0d/%h/%h exp=0/0303/55", ev_kind, ev_addr, ev_data); end
      tick();
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL prio_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_overflow();
      ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         full_cycle(16'h1000 + 16'(i), 4'b0010, 1'b0, 8'h10 + 8'(i));
      end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
      tick();
      tick();
      checks++; if (ev_addr !== 16'h1000 || ev_data !== 8'h10) begin failures++; $display("FAIL ovf_hold got=%h/%h exp=1000/10", ev_addr, ev_data); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0b exp=0", overflow); end
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (ev_valid !== 1'b1 || ev_addr !== 16'h1000 + 16'(i) || ev_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%0b/%h/%h exp=1/%h/%h", i, ev_valid, ev_addr, ev_data, 16'h1000 + 16'(i), 8'h10 + 8'(i)); end
         tick();
      end
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         full_cycle(16'h2000 + 16'(i), 4'b0010, 1'b0, 8'h20 + 8'(i));
      end
      start_addr(16'h2004);
      strobe(4'b0010, 1'b0);
      ev_ready = 1'b1;
      capture(8'h24);
      ev_ready = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%0b exp=0", overflow); end
      end_ras();
      ev_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checks++; if (ev_valid !== 1'b1 || ev_addr !== 16'h2000 + 16'(i) || ev_data !== 8'h20 + 8'(i)) begin failures++; $display("FAIL b2b_drain%0d got=%0b/%h/%h exp=1/%h/%h", i, ev_valid, ev_addr, ev_data, 16'h2000 + 16'(i), 8'h20 + 8'(i)); end
         tick();
      end
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_timeout();
      int cycles;
      ev_ready = 1'b1;
      negedge_ras_n = 1'b1;
      tick();
      negedge_ras_n = 1'b0;
      cycles = 1;
      while (timeout_err !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
      checks++; if (cycles != 31) begin failures++; $display("FAIL tmo_cycles got=%0d exp=31", cycles); end
      tick();
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tmo_after got=%0b/%0b exp=0/0", timeout_err, busy); end
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL tmo_noevent got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_abort_resync();
      ev_ready = 1'b0;
      negedge_ras_n = 1'b1;
      tick();
      negedge_ras_n = 1'b0;
      end_ras();
      checks++; if (busy !== 1'b0 || ev_valid !== 1'b0) begin failures++; $display("FAIL abort_row got=%0b/%0b exp=0/0", busy, ev_valid); end
      start_addr(16'h1111);
      end_ras();
      checks++; if (busy !== 1'b0 || ev_valid !== 1'b0) begin failures++; $display("FAIL abort_addr got=%0b/%0b exp=0/0", busy, ev_valid); end
      start_addr(16'h1111);
      start_addr(16'h2222);
      strobe(4'b0001, 1'b0);
      capture(8'h99);
      checks++; if (ev_valid !== 1'b1 || ev_kind !== 3'd0 || ev_addr !== 16'h2222 || ev_data !== 8'h99) begin failures++; $display("FAIL resync got=%0b/%0d/%h/%h exp=1/0/2222/99", ev_valid, ev_kind, ev_addr, ev_data); end
      strobe(4'b1000, 1'b1);
      end_ras();
      ev_ready = 1'b1;
      tick();
      checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL wait_end_ignore got=%0b exp=0", ev_valid); end
   endtask

   task automatic test_reset_capture();
      ev_ready = 1'b0;
      full_cycle(16'h3000, 4'b0010, 1'b0, 8'hA0);
      full_cycle(16'h3001, 4'b0010, 1'b0, 8'hA1);
      start_addr(16'h3002);
      strobe(4'b0010, 1'b0);
      reset = 1'b1;
      negedge_ras_n = 1'b1;
      shavv = 8'hA2;
      tick();
      reset = 1'b0;
      negedge_ras_n = 1'b0;
      shavv = 8'h00;
      checks++; if (ev_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rstcap got=%0b/%0b/%0b exp=0/0/0", ev_valid, busy, overflow); end
      ev_ready = 1'b1;
      start_addr(16'h4444);
      strobe(4'b0100, 1'b1);
      capture(8'hC3);
      checks++; if (ev_valid !== 1'b1 || ev_kind !== 3'd6 || ev_addr !== 16'h4444 || ev_data !== 8'hC3) begin failures++; $display("FAIL rstcap_next got=%0b/%0d/%h/%h exp=1/6/4444/c3", ev_valid, ev_kind, ev_addr, ev_data); end
      end_ras();
      checks++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstcap_end got=%0b/%0b exp=0/0", ev_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_priority();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_abort_resync();
      test_reset_capture();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
